// File: rtl/rgb_palette_converter.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_palette_converter
//  Description : Palette index to RGB converter with a run-time writable
//                palette and snap / linear-fade transitions.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_palette_converter #(
    parameter int CH_W  = 8,
    parameter int IDX_W = 3,
    parameter int STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [IDX_W-1:0]    color,
    input  logic                req,
    input  logic                mode,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    output logic                ready,
    output logic [3*CH_W-1:0]   rgb,
    output logic                done
);

    localparam int              c_depth = 2**IDX_W;
    localparam int              c_rgb_w = 3*CH_W;
    localparam logic [CH_W:0]   c_step  = (CH_W+1)'(STEP);

    localparam logic [0:0]      c_idle  = 1'b0;
    localparam logic [0:0]      c_fade  = 1'b1;

    logic [c_rgb_w-1:0] r_palette [c_depth];
    logic [0:0]         r_state;
    logic [0:0]         w_state_nx;
    logic [c_rgb_w-1:0] r_rgb;
    logic [c_rgb_w-1:0] w_rgb_nx;
    logic [c_rgb_w-1:0] r_target;
    logic [c_rgb_w-1:0] w_target_nx;
    logic               r_done;
    logic               w_done_nx;
    logic [c_rgb_w-1:0] w_entry;
    logic [c_rgb_w-1:0] w_fade_rgb;
    logic [2:0]         w_ch_hit;

    // Default entry: each channel is all-ones when its index bit is set.
    function automatic logic [c_rgb_w-1:0] f_default(input int unsigned idx);
        f_default = {{CH_W{idx[2]}}, {CH_W{idx[1]}}, {CH_W{idx[0]}}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_palette[i] <= f_default(i);
            end
        end else if (wr_en) begin
            r_palette[wr_addr] <= wr_data;
        end
    end

    // Combinational read: a same-cycle write is only seen from the next cycle.
    assign w_entry = r_palette[color];

    // Per-channel step toward target, evaluated one bit wider than the channel.
    generate
        for (genvar gc = 0; gc < 3; gc++) begin : g_ch
            logic [CH_W:0] w_cur;
            logic [CH_W:0] w_tgt;
            logic [CH_W:0] w_diff;
            logic [CH_W:0] w_amt;
            logic [CH_W:0] w_next;

            assign w_cur  = {1'b0, r_rgb[gc*CH_W +: CH_W]};
            assign w_tgt  = {1'b0, r_target[gc*CH_W +: CH_W]};
            assign w_diff = (w_tgt > w_cur) ? (w_tgt - w_cur) : (w_cur - w_tgt);
            assign w_amt  = (w_diff > c_step) ? c_step : w_diff;
            assign w_next = (w_tgt > w_cur) ? (w_cur + w_amt) : (w_cur - w_amt);

            assign w_fade_rgb[gc*CH_W +: CH_W] = w_next[CH_W-1:0];
            assign w_ch_hit[gc]                = (w_next == w_tgt);
        end
    endgenerate

    always_comb begin
        w_state_nx  = r_state;
        w_rgb_nx    = r_rgb;
        w_target_nx = r_target;
        w_done_nx   = 1'b0;
        if (enable) begin
            case (r_state)
                c_idle: begin
                    if (req) begin
                        if (!mode || (w_entry == r_rgb)) begin
                            w_rgb_nx  = w_entry;
                            w_done_nx = 1'b1;
                        end else begin
                            w_target_nx = w_entry;
                            w_state_nx  = c_fade;
                        end
                    end
                end
                c_fade: begin
                    w_rgb_nx = w_fade_rgb;
                    if (&w_ch_hit) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = c_idle;
                    end
                end
                default: begin
                    w_state_nx = c_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_rgb    <= '0;
            r_target <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_rgb    <= w_rgb_nx;
            r_target <= w_target_nx;
            r_done   <= w_done_nx;
        end
    end

    assign ready = enable && (r_state == c_idle);
    assign rgb   = r_rgb;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rgb_palette_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_palette_converter
//  Description : Directed self-checking bench with a cycle-level colour model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_palette_converter;

    localparam int CH_W  = 8;
    localparam int IDX_W = 3;
    localparam int STEP  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  color;
    logic        req;
    logic        mode;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        ready;
    logic [23:0] rgb;
    logic        done;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    logic [23:0] m_pal [8];
    logic [23:0] m_rgb;
    logic [23:0] m_target;
    bit          m_fade;
    bit          m_done;

    logic [23:0] snap_exp [8];

    always #5 clk = ~clk;

    rgb_palette_converter #(
        .CH_W  (CH_W),
        .IDX_W (IDX_W),
        .STEP  (STEP)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .color   (color),
        .req     (req),
        .mode    (mode),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready),
        .rgb     (rgb),
        .done    (done)
    );

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dflt(input int i);
        return {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
    endfunction

    function automatic int approach(input int c, input int t);
        if (t > c) return (t - c > STEP) ? c + STEP : t;
        if (t < c) return (c - t > STEP) ? c - STEP : t;
        return c;
    endfunction

    // Advance the model by one clock edge from the inputs present at that edge.
    task automatic model_step();
        logic [23:0] e;
        int          v;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_pal[i] = dflt(i);
            m_rgb = '0; m_target = '0; m_fade = 0; m_done = 0;
        end else begin
            e      = m_pal[color];
            m_done = 0;
            if (enable) begin
                if (!m_fade) begin
                    if (req) begin
                        if (!mode || e == m_rgb) begin
                            m_rgb = e; m_done = 1;
                        end else begin
                            m_target = e; m_fade = 1;
                        end
                    end
                end else begin
                    for (int ch = 0; ch < 3; ch++) begin
                        v = approach(int'(m_rgb[ch*8 +: 8]), int'(m_target[ch*8 +: 8]));
                        m_rgb[ch*8 +: 8] = v[7:0];
                    end
                    if (m_rgb == m_target) begin
                        m_done = 1; m_fade = 0;
                    end
                end
            end
            if (wr_en) m_pal[wr_addr] = wr_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("cyc_rgb", rgb, m_rgb);
                chk("cyc_done", {23'd0, done}, {23'd0, m_done});
                chk("cyc_ready", {23'd0, ready}, {23'd0, enable && !m_fade});
            end
        end
    end

    initial begin
        int v;
        snap_exp = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                     24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        rst = 1; enable = 0; color = 0; req = 0; mode = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        tick();
        check_en = 1;
        tick();
        rst = 0; enable = 1;
        #1;
        chk("rst_rgb", rgb, 24'h000000);
        chk("rst_done", {23'd0, done}, 24'd0);
        chk("rst_ready", {23'd0, ready}, 24'd1);

        // Disabled request must not be accepted
        enable = 0; req = 1; color = 7;
        #1;
        chk("dis_ready", {23'd0, ready}, 24'd0);
        tick();
        chk("dis_rgb", rgb, 24'h000000);

        // Snap sweep over the default palette
        enable = 1; mode = 0;
        for (int c = 0; c < 8; c++) begin
            color = 3'(c); req = 1;
            tick();
            chk("snap_rgb", rgb, snap_exp[c]);
            chk("snap_done", {23'd0, done}, 24'd1);
        end
        req = 0;

        // Palette writes and same-cycle write/read ordering
        wr_en = 1; wr_addr = 2; wr_data = 24'h123456;
        tick();
        wr_en = 0; req = 1; color = 2;
        tick();
        chk("wr_snap2", rgb, 24'h123456);
        wr_en = 1; wr_addr = 3; wr_data = 24'hABCDEF; color = 3;
        tick();
        chk("wr_same_cycle", rgb, 24'h00FFFF);
        wr_en = 0;
        tick();
        chk("wr_after", rgb, 24'hABCDEF);

        // Fade to a colour equal to current rgb behaves like a snap
        color = 0; mode = 0;
        tick();
        mode = 1;
        tick();
        chk("fade_eq_rgb", rgb, 24'h000000);
        chk("fade_eq_done", {23'd0, done}, 24'd1);
        chk("fade_eq_ready", {23'd0, ready}, 24'd1);

        // Fade 000000 -> FFFFFF; a request mid-fade is ignored
        color = 7; mode = 1; req = 1;
        tick();
        chk("fu_accept_ready", {23'd0, ready}, 24'd0);
        chk("fu_accept_rgb", rgb, 24'h000000);
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin req = 1; color = 2; mode = 0; end
            else req = 0;
            tick();
            v = (16 * k > 255) ? 255 : 16 * k;
            chk("fu_rgb", rgb, {v[7:0], v[7:0], v[7:0]});
            chk("fu_done", {23'd0, done}, {23'd0, k == 16});
        end
        req = 0;

        // Fade FFFFFF -> FF0000 with enable dropped for three cycles
        color = 4; mode = 1; req = 1;
        tick();
        req = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            v = (255 - 16 * k < 0) ? 0 : 255 - 16 * k;
            chk("fd_rgb", rgb, {8'hFF, v[7:0], v[7:0]});
            chk("fd_done", {23'd0, done}, {23'd0, k == 16});
            if (k == 4) begin
                enable = 0;
                repeat (3) begin
                    tick();
                    chk("fd_hold_rgb", rgb, 24'hFFBFBF);
                    chk("fd_hold_done", {23'd0, done}, 24'd0);
                end
                enable = 1;
            end
        end

        // Reset in the middle of a fade restores palette defaults
        color = 0; mode = 0; req = 1;
        tick();
        color = 7; mode = 1;
        tick();
        req = 0;
        for (int k = 1; k <= 7; k++) tick();
        chk("rf_k7", rgb, 24'h707070);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rf_rgb", rgb, 24'h000000);
        chk("rf_done", {23'd0, done}, 24'd0);
        chk("rf_ready", {23'd0, ready}, 24'd1);
        color = 2; mode = 0; req = 1;
        tick();
        chk("rf_default2", rgb, 24'h00FF00);
        req = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
